dac_burst_tx: RTL

DAC_BURST_TX -- requirements
Module: dac_burst_tx

---
 rtl/dac_burst_tx_pkg.sv | 24 ++
 rtl/dac_burst_tx_ch.sv | 162 ++++++++++++++++
 rtl/dac_burst_tx.sv | 80 ++++++++
 3 files changed

// File: rtl/dac_burst_tx_pkg.sv
// Shared definitions for the burst DAC playback block: channel FSM encoding,
// register address field layout and counter widths.
package dac_burst_tx_pkg;

   localparam int SAMPLE_W   = 16;
   localparam int RATE_W     = 4;
   localparam int CH_FIELD_W = 4;
   localparam int GAP_W      = 16;
   // Largest hold is 2^(2^RATE_W - 1) beats, so the hold counter never needs more bits.
   localparam int HOLD_W     = (1 << RATE_W) - 1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PLAY = 2'd1,
      ST_GAP  = 2'd2,
      ST_DONE = 2'd3
   } ch_state_e;

   // Channel select sits directly above the sample index in reg_addr.
   function automatic logic [CH_FIELD_W-1:0] addr_ch(input logic [15:0] addr, input int pcmaw);
      return addr[pcmaw +: CH_FIELD_W];
   endfunction

endpackage

// File: rtl/dac_burst_tx_ch.sv
// One playback channel: sample RAM with a register port, burst/gap/hold
// sequencing FSM and the output beat register.
module dac_burst_ch
   import dac_burst_tx_pkg::*;
#(
   parameter int PCMAW = 10,
   parameter int REPW  = 8
) (
   input  logic                clk_2,
   input  logic                rst,
   input  logic                wr_en_i,
   input  logic [PCMAW-1:0]    addr_i,
   input  logic [SAMPLE_W-1:0] wdata_i,
   output logic [SAMPLE_W-1:0] rdata_o,
   input  logic [PCMAW-1:0]    sig_len_i,
   input  logic [REPW-1:0]     rep_cnt_i,
   input  logic [GAP_W-1:0]    gap_len_i,
   input  logic [RATE_W-1:0]   hold_rate_i,
   input  logic                run_i,
   input  logic                ready_i,
   output logic                valid_o,
   output logic [SAMPLE_W-1:0] pcm_o,
   output logic                done_o
);

   logic [SAMPLE_W-1:0] mem_q [2**PCMAW];
   logic [SAMPLE_W-1:0] rdata_q, pcm_q;
   ch_state_e           state_q, state_d;
   logic                run_q, rise, ld, hold_last;
   logic                prime_q, prime_d, fin_q, fin_d, vld_q, vld_d;
   logic [PCMAW-1:0]    idx_q, idx_d, len_q;
   logic [HOLD_W-1:0]   hold_q, hold_d;
   logic [REPW-1:0]     burst_q, burst_d, rep_q;
   logic [GAP_W-1:0]    gap_q, gap_d, gapl_q;
   logic [RATE_W-1:0]   rate_q;

   always_ff @(posedge clk_2) begin
      if (wr_en_i) mem_q[addr_i] <= wdata_i;
      rdata_q <= mem_q[addr_i];
   end

   assign rise      = run_i & ~run_q;
   assign hold_last = (32'(hold_q) == ((32'd1 << rate_q) - 32'd1));

   // Counters describe the next beat to load into the output register,
   // which doubles as the RAM read register so a stalled beat costs nothing.
   always_comb begin
      state_d = state_q;
      prime_d = prime_q;
      fin_d   = fin_q;
      vld_d   = vld_q;
      idx_d   = idx_q;
      hold_d  = hold_q;
      burst_d = burst_q;
      gap_d   = gap_q;
      ld      = 1'b0;
      if (!run_i) begin
         state_d = ST_IDLE;
         vld_d   = 1'b0;
         prime_d = 1'b0;
         fin_d   = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: if (rise) begin
               state_d = ST_PLAY;
               prime_d = 1'b1;
               fin_d   = 1'b0;
               idx_d   = '0;
               hold_d  = '0;
               burst_d = '0;
               gap_d   = '0;
            end
            ST_PLAY: begin
               if (len_q == '0) begin
                  state_d = ST_DONE;
               end else if (prime_q) begin
                  prime_d = 1'b0;
               end else if (fin_q) begin
                  // Last beat is in flight; finish only once it has been taken.
                  if (ready_i) begin
                     vld_d   = 1'b0;
                     state_d = ST_DONE;
                  end
               end else if (!vld_q || ready_i) begin
                  ld    = 1'b1;
                  vld_d = 1'b1;
                  if (!hold_last) begin
                     hold_d = hold_q + HOLD_W'(1);
                  end else begin
                     hold_d = '0;
                     if (idx_q != len_q - PCMAW'(1)) begin
                        idx_d = idx_q + PCMAW'(1);
                     end else begin
                        idx_d   = '0;
                        burst_d = burst_q + REPW'(1);
                        if (rep_q != '0 && burst_d == rep_q) begin
                           fin_d = 1'b1;
                        end else if (gapl_q != '0) begin
                           state_d = ST_GAP;
                           gap_d   = '0;
                        end
                     end
                  end
               end
            end
            ST_GAP: if (!vld_q || ready_i) begin
               ld    = 1'b1;
               vld_d = 1'b1;
               if (gap_q == gapl_q - GAP_W'(1)) begin
                  gap_d   = '0;
                  state_d = ST_PLAY;
               end else begin
                  gap_d = gap_q + GAP_W'(1);
               end
            end
            default: vld_d = 1'b0;
         endcase
      end
   end

   always_ff @(posedge clk_2) begin
      // Tracks run through reset so a level held high cannot look like a new edge.
      run_q <= run_i;
      if (rst) begin
         state_q <= ST_IDLE;
         prime_q <= 1'b0;
         fin_q   <= 1'b0;
         vld_q   <= 1'b0;
         idx_q   <= '0;
         hold_q  <= '0;
         burst_q <= '0;
         gap_q   <= '0;
         pcm_q   <= '0;
         len_q   <= '0;
         rep_q   <= '0;
         gapl_q  <= '0;
         rate_q  <= '0;
      end else begin
         state_q <= state_d;
         prime_q <= prime_d;
         fin_q   <= fin_d;
         vld_q   <= vld_d;
         idx_q   <= idx_d;
         hold_q  <= hold_d;
         burst_q <= burst_d;
         gap_q   <= gap_d;
         if (ld) pcm_q <= (state_q == ST_GAP) ? '0 : mem_q[idx_q];
         if (rise) begin
            len_q  <= sig_len_i;
            rep_q  <= rep_cnt_i;
            gapl_q <= gap_len_i;
            rate_q <= hold_rate_i;
         end
      end
   end

   assign rdata_o = rdata_q;
   assign valid_o = vld_q;
   assign pcm_o   = pcm_q;
   assign done_o  = (state_q == ST_DONE);

endmodule

// File: rtl/dac_burst_tx.sv
// Multi-channel burst DAC player: register port into per-channel sample RAMs
// and CHANNEL independent playback engines sharing one run level.
module dac_burst_tx
   import dac_burst_tx_pkg::*;
#(
   parameter int CHANNEL = 3,
   parameter int PCMAW   = 10,
   parameter int REPW    = 8
) (
   input  logic                         clk_2,
   input  logic                         rst,
   input  logic [15:0]                  reg_addr,
   input  logic                         reg_rd,
   input  logic                         reg_wr,
   input  logic [31:0]                  reg_writedata,
   output logic [31:0]                  reg_readdata,
   output logic                         reg_ready,
   input  logic [PCMAW*CHANNEL-1:0]     sig_len,
   input  logic [REPW*CHANNEL-1:0]      rep_cnt,
   input  logic [GAP_W*CHANNEL-1:0]     gap_len,
   input  logic [RATE_W*CHANNEL-1:0]    hold_rate,
   input  logic                         run,
   output logic [CHANNEL-1:0]           pcm_out_valid,
   input  logic [CHANNEL-1:0]           pcm_out_ready,
   output logic [SAMPLE_W*CHANNEL-1:0]  pcm_out,
   output logic [CHANNEL-1:0]           ch_done
);

   logic [CH_FIELD_W-1:0]             acc_ch, rd_ch_q;
   logic                              rd_pend_q, ready_q;
   logic [CHANNEL-1:0][SAMPLE_W-1:0]  ch_rdata;
   logic [SAMPLE_W-1:0]               rdata_mux;
   logic                              unused_bits;

   assign acc_ch      = addr_ch(reg_addr, PCMAW);
   assign unused_bits = ^{reg_writedata[31:SAMPLE_W], reg_addr[15:PCMAW+CH_FIELD_W]};

   always_ff @(posedge clk_2) begin
      if (rst) begin
         rd_pend_q <= 1'b0;
         rd_ch_q   <= '0;
         ready_q   <= 1'b0;
      end else begin
         rd_pend_q <= reg_rd;
         rd_ch_q   <= acc_ch;
         ready_q   <= reg_rd | reg_wr;
      end
   end

   // A channel number with no engine behind it matches nothing and reads as zero.
   always_comb begin
      rdata_mux = '0;
      for (int i = 0; i < CHANNEL; i++)
         if (rd_pend_q && rd_ch_q == CH_FIELD_W'(i)) rdata_mux = ch_rdata[i];
   end

   assign reg_readdata = {16'h0000, rdata_mux};
   assign reg_ready    = ready_q;

   for (genvar g = 0; g < CHANNEL; g++) begin : g_ch
      dac_burst_ch #(.PCMAW(PCMAW), .REPW(REPW)) u_ch (
         .clk_2       (clk_2),
         .rst         (rst),
         .wr_en_i     (reg_wr && acc_ch == CH_FIELD_W'(g)),
         .addr_i      (reg_addr[PCMAW-1:0]),
         .wdata_i     (reg_writedata[SAMPLE_W-1:0]),
         .rdata_o     (ch_rdata[g]),
         .sig_len_i   (sig_len[g*PCMAW +: PCMAW]),
         .rep_cnt_i   (rep_cnt[g*REPW +: REPW]),
         .gap_len_i   (gap_len[g*GAP_W +: GAP_W]),
         .hold_rate_i (hold_rate[g*RATE_W +: RATE_W]),
         .run_i       (run),
         .ready_i     (pcm_out_ready[g]),
         .valid_o     (pcm_out_valid[g]),
         .pcm_o       (pcm_out[g*SAMPLE_W +: SAMPLE_W]),
         .done_o      (ch_done[g])
      );
   end

endmodule
